// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with sign correction in a final FIX cycle and direct MTHI/MTLO moves.
module muldiv_unit #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_OPERATION = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_OPERATION-1:0] i_op,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  input  logic                    i_cancel,
  output logic [NB_DATA-1:0]      o_hi,
  output logic [NB_DATA-1:0]      o_lo,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_div_zero
);

  localparam int unsigned NB_CNT = $clog2(NB_DATA);
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DATA - 1);

  localparam logic [NB_OPERATION-1:0] OP_MULT  = NB_OPERATION'(0);
  localparam logic [NB_OPERATION-1:0] OP_MULTU = NB_OPERATION'(1);
  localparam logic [NB_OPERATION-1:0] OP_DIV   = NB_OPERATION'(2);
  localparam logic [NB_OPERATION-1:0] OP_DIVU  = NB_OPERATION'(3);
  localparam logic [NB_OPERATION-1:0] OP_MTHI  = NB_OPERATION'(4);
  localparam logic [NB_OPERATION-1:0] OP_MTLO  = NB_OPERATION'(5);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  acc_hi_q, acc_hi_d;
  logic [NB_DATA-1:0]  acc_lo_q, acc_lo_d;
  logic [NB_DATA-1:0]  opnd_q, opnd_d;
  logic [NB_DATA-1:0]  hi_q, hi_d;
  logic [NB_DATA-1:0]  lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                b_zero_q, b_zero_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  logic                op_signed, op_launch, op_is_div;
  logic                a_neg, b_neg;
  logic [NB_DATA-1:0]  a_mag, b_mag;
  logic [NB_DATA:0]    mul_sum;
  logic [NB_DATA:0]    div_shift;
  logic [NB_DATA-1:0]  div_diff;
  logic                div_ge;
  logic [2*NB_DATA-1:0] prod, prod_fix;
  logic [NB_DATA-1:0]  quo_fix, rem_fix;

  assign op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign op_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign op_launch = (i_op == OP_MULT) || (i_op == OP_MULTU) || op_is_div;

  assign a_neg = op_signed & i_data_a[NB_DATA-1];
  assign b_neg = op_signed & i_data_b[NB_DATA-1];
  assign a_mag = a_neg ? -i_data_a : i_data_a;
  assign b_mag = b_neg ? -i_data_b : i_data_b;

  // Multiply: acc_lo holds the multiplier and shifts out as product bits shift in from acc_hi.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi_q, acc_lo_q[NB_DATA-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[NB_DATA-1:0] - opnd_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  // A zero divisor leaves |a| as remainder, so the dividend sign restores HI = a.
  assign quo_fix  = b_zero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (i_start && !i_cancel) begin
          if (op_launch) begin
            state_d   = StCalc;
            cnt_d     = '0;
            acc_hi_d  = '0;
            acc_lo_d  = op_is_div ? a_mag : b_mag;
            opnd_d    = op_is_div ? b_mag : a_mag;
            is_div_d  = op_is_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            b_zero_d  = (i_data_b == '0);
          end else if (i_op == OP_MTHI) begin
            hi_d = i_data_a;
          end else if (i_op == OP_MTLO) begin
            lo_d = i_data_a;
          end
        end
      end
      StCalc: begin
        if (i_cancel) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_ge ? div_diff : div_shift[NB_DATA-1:0];
            acc_lo_d = {acc_lo_q[NB_DATA-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[NB_DATA:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[NB_DATA-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!i_cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d       = rem_fix;
            lo_d       = quo_fix;
            div_zero_d = b_zero_q;
          end else begin
            hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
            lo_d = prod_fix[NB_DATA-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning operand, HI and LO width (even, >= 4).
REQ-002 The block SHALL have parameter NB_OPERATION, default 3, meaning width of i_op.
REQ-003 The block SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_start, input, 1, request to launch or execute i_op.
REQ-006 The block SHALL have port i_op, input, NB_OPERATION, operation code: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; others are no-op.
REQ-007 The block SHALL have port i_data_a, input, NB_DATA, multiplicand / dividend / move source.
REQ-008 The block SHALL have port i_data_b, input, NB_DATA, multiplier / divisor.
REQ-009 The block SHALL have port i_cancel, input, 1, abort of an in-flight operation.
REQ-010 The block SHALL have port o_hi, output, NB_DATA, HI register.
REQ-011 The block SHALL have port o_lo, output, NB_DATA, LO register.
REQ-012 The block SHALL have port o_busy, output, 1, high while a multi-cycle operation is in flight.
REQ-013 The block SHALL have port o_done, output, 1, one-cycle pulse when HI/LO take a multiply/divide result.
REQ-014 The block SHALL have port o_div_zero, output, 1, sticky flag: last completed divide had divisor zero.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, FIX; reset state IDLE.
REQ-016 In IDLE, with i_start high and i_op MULT/MULTU/DIV/DIVU, the block SHALL latch operands and op at edge E0 and enter CALC; o_busy high from E0.
REQ-017 CALC SHALL perform one iteration per cycle for exactly NB_DATA cycles (edges E1..E_NB_DATA), then enter FIX.
REQ-018 FIX SHALL apply sign correction, write HI/LO at edge E_NB_DATA+1, pulse o_done high for that following cycle, drop o_busy and return to IDLE.
REQ-019 Total latency SHALL be NB_DATA+1 edges after E0; a new i_start SHALL be accepted on the cycle o_done is high.
REQ-020 i_start while o_busy is high SHALL be ignored; operands SHALL not be re-sampled.
REQ-021 MULTU: {HI,LO} SHALL equal the 2*NB_DATA-bit unsigned product via shift-add.
REQ-022 MULT: operands SHALL be converted to magnitude, multiplied unsigned, and the product negated in FIX if signs differ; {HI,LO} is the 2*NB_DATA two's-complement product.
REQ-023 DIVU: LO SHALL be the quotient and HI the remainder via restoring division.
REQ-024 DIV: the quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-025 Signed overflow (most-negative / -1) SHALL give LO = most-negative value and HI = 0.
REQ-026 Divisor zero (DIV or DIVU) SHALL still take the full latency, give LO = all ones and HI = i_data_a, and set o_div_zero.
REQ-027 o_div_zero SHALL be cleared by the next completed divide with a non-zero divisor.
REQ-028 MTHI/MTLO with i_start in IDLE SHALL write i_data_a to HI/LO at that edge with no o_busy and no o_done.
REQ-029 MTHI/MTLO while busy SHALL be ignored.
REQ-030 i_cancel high in CALC or FIX SHALL return to IDLE at the next edge, leave HI/LO and o_div_zero unchanged, suppress o_done and drop o_busy.
REQ-031 i_cancel and i_start in the same IDLE cycle: i_cancel SHALL have priority and nothing SHALL launch.
REQ-032 HI/LO SHALL change only at FIX completion or on MTHI/MTLO.

Reset
REQ-033 i_reset low SHALL immediately force IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0 and clear internal accumulators.
REQ-034 Reset assertion mid-operation SHALL discard the operation; no o_done after release.
REQ-035 The first start SHALL be accepted on the first rising edge after i_reset deasserts.

Verification
REQ-036 MULT a=0xFFFFFFFD (-3), b=7 -> o_done after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
REQ-039 DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100, o_div_zero=1; then DIVU 9/4 -> LO=2, HI=1, o_div_zero=0.
REQ-040 MTLO 0x1234 then MULT started, i_cancel at cycle 10 -> o_busy low next cycle, no o_done, LO stays 0x1234; second start during busy ignored.
REQ-041 Reset asserted at cycle 5 of DIVU -> all outputs 0 immediately; no o_done after release.
